// File: rtl/rv_pkg.sv
// Shared writeback-path definitions: source-select encodings and register index constants.
package rv_pkg;

   localparam int REG_IDX_W = 5;

   typedef enum logic [1:0] {
      WB_SRC_HALF     = 2'b00,
      WB_SRC_MEM      = 2'b01,
      WB_SRC_HALF_ALT = 2'b10,
      WB_SRC_ZERO     = 2'b11
   } wb_src_e;

   localparam logic [REG_IDX_W-1:0] X0 = '0;

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB-to-regfile bus: writeback request, decode read ports and forwarding outputs.
interface wb_regfile_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 64
);
   import rv_pkg::*;

   logic                 regesterW;
   logic [1:0]           regSrc;
   logic [REG_IDX_W-1:0] Rd;
   logic [XLEN-1:0]      reg_write_data_half;
   logic [XLEN-1:0]      Mout;
   logic                 stall;
   logic [REG_IDX_W-1:0] rs1;
   logic [REG_IDX_W-1:0] rs2;
   logic [XLEN-1:0]      rd1;
   logic [XLEN-1:0]      rd2;
   logic [XLEN-1:0]      wb_data;
   logic                 wb_en;
   logic [CNT_W-1:0]     instret;

   modport master (
      output regesterW, regSrc, Rd, reg_write_data_half, Mout, stall, rs1, rs2,
      input  rd1, rd2, wb_data, wb_en, instret
   );

   modport slave (
      input  regesterW, regSrc, Rd, reg_write_data_half, Mout, stall, rs1, rs2,
      output rd1, rd2, wb_data, wb_en, instret
   );

endinterface

// File: rtl/wb_select.sv
// Combinational writeback source mux; also instantiated by the EX forwarding unit.
module wb_select
   import rv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [1:0]      sel,
   input  logic [XLEN-1:0] half,
   input  logic [XLEN-1:0] mem,
   output logic [XLEN-1:0] data
);

   always_comb begin
      data = '0;
      case (wb_src_e'(sel))
         WB_SRC_HALF:     data = half;
         WB_SRC_MEM:      data = mem;
         WB_SRC_HALF_ALT: data = half;
         WB_SRC_ZERO:     data = '0;
         default:         data = '0;
      endcase
   end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects the result, commits it to the integer register file,
// serves two bypassed read ports and counts retired writebacks.
module wb_regfile
   import rv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NREG  = 32,
   parameter int CNT_W = 64
) (
   input logic         clk,
   input logic         rst,
   wb_regfile_if.slave bus
);

   logic [XLEN-1:0]  regs_q [NREG];
   logic [XLEN-1:0]  regs_d [NREG];
   logic [CNT_W-1:0] instret_q;
   logic [CNT_W-1:0] instret_d;
   logic [XLEN-1:0]  wb_data;
   logic             wb_en;
   logic             retire;

   wb_select #(.XLEN(XLEN)) u_sel (
      .sel  (bus.regSrc),
      .half (bus.reg_write_data_half),
      .mem  (bus.Mout),
      .data (wb_data)
   );

   // A held instruction commits and retires only on the first unstalled cycle.
   assign retire = bus.regesterW & ~bus.stall;
   assign wb_en  = retire & (bus.Rd != X0);

   always_comb begin
      regs_d = regs_q;
      if (wb_en) regs_d[bus.Rd] = wb_data;
      instret_d = instret_q;
      if (retire) instret_d = instret_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
         instret_q <= '0;
      end else begin
         regs_q    <= regs_d;
         instret_q <= instret_d;
      end
   end

   // Same-cycle bypass lets ID see the value being written this edge.
   always_comb begin
      bus.rd1 = regs_q[bus.rs1];
      if (bus.rs1 == X0)                     bus.rd1 = '0;
      else if (wb_en && (bus.Rd == bus.rs1)) bus.rd1 = wb_data;

      bus.rd2 = regs_q[bus.rs2];
      if (bus.rs2 == X0)                     bus.rd2 = '0;
      else if (wb_en && (bus.Rd == bus.rs2)) bus.rd2 = wb_data;
   end

   assign bus.wb_data = wb_data;
   assign bus.wb_en   = wb_en;
   assign bus.instret = instret_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, writes, bypass, x0, stall hold, reset priority, counter wrap.
module tb_wb_regfile;
   import rv_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   wb_regfile_if #(.XLEN(32), .CNT_W(64)) bus ();

   wb_regfile #(.XLEN(32), .NREG(32), .CNT_W(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) begin
      if (bus.regesterW === 1'b1)
         assert (!$isunknown(bus.regSrc) && !$isunknown(bus.Rd))
         else begin
            errors++;
            $error("FAIL xsel: regSrc %b Rd %b unknown with regesterW set", bus.regSrc, bus.Rd);
         end
   end

   task automatic drive(input logic we, input logic [1:0] src, input logic [4:0] rd,
                        input logic [31:0] half, input logic [31:0] mem, input logic stl,
                        input logic [4:0] a, input logic [4:0] b);
      bus.regesterW           = we;
      bus.regSrc              = src;
      bus.Rd                  = rd;
      bus.reg_write_data_half = half;
      bus.Mout                = mem;
      bus.stall               = stl;
      bus.rs1                 = a;
      bus.rs2                 = b;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0);
      repeat (2) @(posedge clk);

      // reset then read
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 1'b0, 5'd5, 5'd31);
      #1;
      check("rst_rd1", 64'(bus.rd1), 64'h0);
      check("rst_rd2", 64'(bus.rd2), 64'h0);
      check("rst_instret", bus.instret, 64'h0);

      // source select, no write
      drive(1'b0, 2'b10, 5'd3, 32'h0BAD_F00D, 32'h1111_2222, 1'b0, 5'd5, 5'd31);
      #1;
      check("sel_alt", 64'(bus.wb_data), 64'h0BAD_F00D);
      check("wben_idle", 64'(bus.wb_en), 64'h0);
      drive(1'b0, 2'b11, 5'd3, 32'h0BAD_F00D, 32'h1111_2222, 1'b0, 5'd5, 5'd31);
      #1;
      check("sel_zero", 64'(bus.wb_data), 64'h0);

      // basic writes
      @(negedge clk);
      drive(1'b1, 2'b00, 5'd3, 32'hDEAD_BEEF, 32'h0, 1'b0, 5'd5, 5'd31);
      #1;
      check("sel_half", 64'(bus.wb_data), 64'hDEAD_BEEF);
      check("wben_w3", 64'(bus.wb_en), 64'h1);
      @(negedge clk);
      drive(1'b1, 2'b01, 5'd4, 32'hCAFE_0000, 32'h1234_5678, 1'b0, 5'd5, 5'd31);
      #1;
      check("sel_mem", 64'(bus.wb_data), 64'h1234_5678);
      @(negedge clk);
      drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 1'b0, 5'd3, 5'd4);
      #1;
      check("rd_x3", 64'(bus.rd1), 64'hDEAD_BEEF);
      check("rd_x4", 64'(bus.rd2), 64'h1234_5678);
      check("instret_2", bus.instret, 64'd2);

      // bypass on both ports
      drive(1'b1, 2'b00, 5'd7, 32'hA5A5_A5A5, 32'h0, 1'b0, 5'd7, 5'd7);
      #1;
      check("byp_rd1", 64'(bus.rd1), 64'hA5A5_A5A5);
      check("byp_rd2", 64'(bus.rd2), 64'hA5A5_A5A5);

      // write to x0
      @(negedge clk);
      drive(1'b1, 2'b00, 5'd0, 32'hFFFF_FFFF, 32'h0, 1'b0, 5'd0, 5'd7);
      #1;
      check("x0_rd1", 64'(bus.rd1), 64'h0);
      check("x0_wben", 64'(bus.wb_en), 64'h0);
      check("x7_commit", 64'(bus.rd2), 64'hA5A5_A5A5);
      @(negedge clk);
      drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd7);
      #1;
      check("x0_after", 64'(bus.rd1), 64'h0);
      check("instret_4", bus.instret, 64'd4);

      // stall hold: old value in x9 first
      drive(1'b1, 2'b00, 5'd9, 32'h77, 32'h0, 1'b0, 5'd0, 5'd0);
      @(negedge clk);
      drive(1'b1, 2'b00, 5'd9, 32'h11, 32'h0, 1'b1, 5'd9, 5'd0);
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall_rd1", 64'(bus.rd1), 64'h77);
         check("stall_wben", 64'(bus.wb_en), 64'h0);
         @(negedge clk);
      end
      #1;
      check("stall_instret", bus.instret, 64'd5);
      bus.stall = 1'b0;
      #1;
      check("release_byp", 64'(bus.rd1), 64'h11);
      @(negedge clk);
      bus.regesterW = 1'b0;
      #1;
      check("stall_commit", 64'(bus.rd1), 64'h11);
      check("stall_once", bus.instret, 64'd6);

      // reset priority over a write
      @(negedge clk);
      rst = 1'b1;
      drive(1'b1, 2'b00, 5'd10, 32'h55, 32'h0, 1'b0, 5'd10, 5'd9);
      @(negedge clk);
      rst = 1'b0;
      bus.regesterW = 1'b0;
      #1;
      check("rstpri_x10", 64'(bus.rd1), 64'h0);
      check("rstpri_x9", 64'(bus.rd2), 64'h0);
      check("rstpri_instret", bus.instret, 64'h0);

      // counter wrap
      @(negedge clk);
      force dut.instret_q = '1;
      #1;
      release dut.instret_q;
      #1;
      check("preload", bus.instret, 64'hFFFF_FFFF_FFFF_FFFF);
      drive(1'b1, 2'b00, 5'd12, 32'h1, 32'h0, 1'b0, 5'd12, 5'd0);
      @(negedge clk);
      bus.regesterW = 1'b0;
      #1;
      check("wrap", bus.instret, 64'h0);
      check("wrap_x12", 64'(bus.rd1), 64'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
